// File: rtl/nonce_sweeper_if.sv
// nonce_sweeper_if
// Bundles the sweep control, configuration, hash-core and result signals of
// nonce_sweeper. The slave modport is the sweeper's view; the master modport
// is the view of whoever commands the sweep and emulates the hash core.
//   start/abort            sweep commands
//   base/max_nonce/target  sweep configuration, sampled on an accepted start
//   H/hash_valid           result from the hash core
//   fill/bloque_in         block-load strobe and block to the hash core
//   busy/done              sweep status
//   found/timeout_err/aborted/nonce_found/hash_found/attempts  sweep results
interface nonce_sweeper_if #(
  parameter int BLOCK_W = 128,
  parameter int NONCE_W = 32,
  parameter int HASH_W  = 24
);
  logic                       start;
  logic                       abort;
  logic [BLOCK_W-NONCE_W-1:0] base;
  logic [NONCE_W-1:0]         max_nonce;
  logic [HASH_W-1:0]          target;
  logic [HASH_W-1:0]          H;
  logic                       hash_valid;
  logic                       fill;
  logic [BLOCK_W-1:0]         bloque_in;
  logic                       busy;
  logic                       done;
  logic                       found;
  logic                       timeout_err;
  logic                       aborted;
  logic [NONCE_W-1:0]         nonce_found;
  logic [HASH_W-1:0]          hash_found;
  logic [NONCE_W:0]           attempts;

  modport slave (
    input  start, abort, base, max_nonce, target, H, hash_valid,
    output fill, bloque_in, busy, done, found, timeout_err, aborted,
           nonce_found, hash_found, attempts
  );

  modport master (
    output start, abort, base, max_nonce, target, H, hash_valid,
    input  fill, bloque_in, busy, done, found, timeout_err, aborted,
           nonce_found, hash_found, attempts
  );
endinterface

// File: rtl/nonce_sweeper.sv
// nonce_sweeper
// On-chip nonce search for the micro_ucr_hash core. A start builds blocks
// {base, nonce} for nonce = 0..max_nonce, loads each into the core with a
// one-cycle fill, waits for the hash, and stops on the first H < target,
// on nonce exhaustion, on a per-block timeout, or on abort.
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous active-high reset; returns to IDLE, clears all outputs
//   sw     nonce_sweeper_if.slave: commands, configuration, hash-core
//          handshake and sweep results
module nonce_sweeper #(
  parameter int BLOCK_W = 128,
  parameter int NONCE_W = 32,
  parameter int HASH_W  = 24,
  parameter int TIMEOUT = 255
) (
  input  logic           clk,
  input  logic           reset,
  nonce_sweeper_if.slave sw
);

  localparam int BASE_W = BLOCK_W - NONCE_W;
  localparam int CNT_W  = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  state_t              state_q, state_d;
  logic [BASE_W-1:0]   base_q, base_d;
  logic [NONCE_W-1:0]  max_q, max_d;
  logic [HASH_W-1:0]   target_q, target_d;
  logic [NONCE_W-1:0]  nonce_q, nonce_d;
  logic [NONCE_W:0]    attempts_q, attempts_d;
  logic [CNT_W-1:0]    wait_q, wait_d;
  logic                found_q, found_d;
  logic                timeout_q, timeout_d;
  logic                aborted_q, aborted_d;
  logic [NONCE_W-1:0]  nonce_found_q, nonce_found_d;
  logic [HASH_W-1:0]   hash_found_q, hash_found_d;
  logic [BLOCK_W-1:0]  bloque_q, bloque_d;

  // Control and visible results: cleared by reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      nonce_q       <= '0;
      attempts_q    <= '0;
      wait_q        <= '0;
      found_q       <= 1'b0;
      timeout_q     <= 1'b0;
      aborted_q     <= 1'b0;
      nonce_found_q <= '0;
      hash_found_q  <= '0;
      bloque_q      <= '0;
    end else begin
      state_q       <= state_d;
      nonce_q       <= nonce_d;
      attempts_q    <= attempts_d;
      wait_q        <= wait_d;
      found_q       <= found_d;
      timeout_q     <= timeout_d;
      aborted_q     <= aborted_d;
      nonce_found_q <= nonce_found_d;
      hash_found_q  <= hash_found_d;
      bloque_q      <= bloque_d;
    end
  end

  // Sweep configuration: always loaded before use, so no reset needed.
  always_ff @(posedge clk) begin
    base_q   <= base_d;
    max_q    <= max_d;
    target_q <= target_d;
  end

  always_comb begin
    state_d       = state_q;
    base_d        = base_q;
    max_d         = max_q;
    target_d      = target_q;
    nonce_d       = nonce_q;
    attempts_d    = attempts_q;
    wait_d        = wait_q;
    found_d       = found_q;
    timeout_d     = timeout_q;
    aborted_d     = aborted_q;
    nonce_found_d = nonce_found_q;
    hash_found_d  = hash_found_q;
    bloque_d      = bloque_q;

    case (state_q)
      IDLE: begin
        if (sw.start) begin
          state_d       = ISSUE;
          base_d        = sw.base;
          max_d         = sw.max_nonce;
          target_d      = sw.target;
          nonce_d       = '0;
          attempts_d    = '0;
          found_d       = 1'b0;
          timeout_d     = 1'b0;
          aborted_d     = 1'b0;
          nonce_found_d = '0;
          hash_found_d  = '0;
          // The block is registered on entry to ISSUE so it is already
          // valid in the fill cycle and holds until the next ISSUE.
          bloque_d      = {sw.base, {NONCE_W{1'b0}}};
        end
      end

      ISSUE: begin
        wait_d = '0;
        if (sw.abort) begin
          aborted_d = 1'b1;
          state_d   = DONE;
        end else begin
          state_d   = WAIT;
        end
      end

      WAIT: begin
        wait_d = wait_q + CNT_W'(1);
        // Abort takes priority; a hash arriving with it is discarded.
        if (sw.abort) begin
          aborted_d = 1'b1;
          state_d   = DONE;
        end else if (sw.hash_valid) begin
          attempts_d = attempts_q + (NONCE_W+1)'(1);
          if (sw.H < target_q) begin
            found_d       = 1'b1;
            nonce_found_d = nonce_q;
            hash_found_d  = sw.H;
            state_d       = DONE;
          end else if (nonce_q == max_q) begin
            state_d = DONE;
          end else begin
            nonce_d  = nonce_q + NONCE_W'(1);
            bloque_d = {base_q, nonce_q + NONCE_W'(1)};
            state_d  = ISSUE;
          end
        end else if (wait_q == CNT_W'(TIMEOUT - 1)) begin
          timeout_d = 1'b1;
          state_d   = DONE;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign sw.fill        = (state_q == ISSUE);
  assign sw.done        = (state_q == DONE);
  assign sw.busy        = (state_q != IDLE);
  assign sw.bloque_in   = bloque_q;
  assign sw.found       = found_q;
  assign sw.timeout_err = timeout_q;
  assign sw.aborted     = aborted_q;
  assign sw.nonce_found = nonce_found_q;
  assign sw.hash_found  = hash_found_q;
  assign sw.attempts    = attempts_q;

endmodule

// File: tb/tb_nonce_sweeper.sv
module tb_nonce_sweeper;
  localparam int BW = 128;
  localparam int NW = 32;
  localparam int HW = 24;
  localparam int TO = 8;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  nonce_sweeper_if #(.BLOCK_W(BW), .NONCE_W(NW), .HASH_W(HW)) sif ();

  nonce_sweeper #(.BLOCK_W(BW), .NONCE_W(NW), .HASH_W(HW), .TIMEOUT(TO)) dut (
    .clk   (clk),
    .reset (reset),
    .sw    (sif.slave)
  );

  int n_tests = 0;
  int n_fail  = 0;

  logic [HW-1:0]    h_tab      [0:15];
  logic [NW-1:0]    fill_nonce [0:15];
  logic [BW-NW-1:0] fill_base  [0:15];
  int               fill_cyc   [0:15];
  int               nfill, done_cyc, last_hv_cyc;

  localparam logic [BW-NW-1:0] BASE_A = 96'hA5A5A5A5_A5A5A5A5_A5A5A5A5;
  localparam logic [BW-NW-1:0] BASE_B = 96'h12345678_9ABCDEF0_0F1E2D3C;

  // Starts a sweep (called at a negedge) and plays the hash core: each fill
  // is answered with hash_valid two cycles later, H taken from h_tab by nonce.
  // Returns at the negedge of the done cycle, or after a cycle budget.
  task automatic run_sweep(input logic [NW-1:0] mx, input logic [HW-1:0] tg,
                           input logic [BW-NW-1:0] bs, input bit respond);
    int pend;
    int cyc;
    logic [NW-1:0] cur;
    sif.base = bs; sif.max_nonce = mx; sif.target = tg; sif.start = 1'b1;
    @(negedge clk);
    sif.start = 1'b0;
    nfill = 0; pend = -1; done_cyc = -1; last_hv_cyc = -1; cyc = 0; cur = '0;
    while (done_cyc < 0 && cyc < 300) begin
      sif.hash_valid = 1'b0;
      if (sif.done) begin
        done_cyc = cyc;
      end else begin
        if (pend == 0) begin
          sif.hash_valid = 1'b1;
          sif.H = h_tab[cur[3:0]];
          last_hv_cyc = cyc;
          pend = -1;
        end else if (pend > 0) begin
          pend--;
        end
        if (sif.fill && nfill < 16) begin
          fill_nonce[nfill] = sif.bloque_in[NW-1:0];
          fill_base[nfill]  = sif.bloque_in[BW-1:NW];
          fill_cyc[nfill]   = cyc;
          cur = sif.bloque_in[NW-1:0];
          nfill++;
          if (respond) pend = 1;
        end
        @(negedge clk);
        cyc++;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    n_tests++;
    if ({sif.fill, sif.busy, sif.done, sif.found, sif.timeout_err, sif.aborted} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_flags: got %b exp 000000",
               {sif.fill, sif.busy, sif.done, sif.found, sif.timeout_err, sif.aborted});
    end
    n_tests++;
    if (sif.bloque_in !== '0 || sif.attempts !== '0 || sif.nonce_found !== '0 || sif.hash_found !== '0) begin
      n_fail++;
      $display("FAIL reset_data: bloque=%h att=%h nf=%h hf=%h exp all 0",
               sif.bloque_in, sif.attempts, sif.nonce_found, sif.hash_found);
    end

    // Reset in the middle of WAIT: no core response, so the sweep sits in WAIT.
    sif.base = BASE_B; sif.max_nonce = 32'd7; sif.target = 24'h000100; sif.start = 1'b1;
    @(negedge clk);
    sif.start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    n_tests++;
    if (sif.busy !== 1'b1 || sif.bloque_in === '0) begin
      n_fail++;
      $display("FAIL pre_reset_busy: busy=%b bloque=%h exp busy 1, block loaded", sif.busy, sif.bloque_in);
    end
    reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      n_tests++;
      if ({sif.fill, sif.busy, sif.done, sif.timeout_err, sif.aborted} !== 5'b0 ||
          sif.bloque_in !== '0 || sif.attempts !== '0) begin
        n_fail++;
        $display("FAIL midreset_outputs: f/b/d/t/a=%b bloque=%h att=%h exp all 0",
                 {sif.fill, sif.busy, sif.done, sif.timeout_err, sif.aborted},
                 sif.bloque_in, sif.attempts);
      end
    end
    reset = 1'b0;
    @(negedge clk);
    n_tests++;
    if (sif.busy !== 1'b0 || sif.done !== 1'b0) begin
      n_fail++;
      $display("FAIL after_reset_idle: busy=%b done=%b exp 0 0", sif.busy, sif.done);
    end
  endtask

  task automatic test_hit();
    h_tab[0] = 24'hFFFFFF; h_tab[1] = 24'hFFFFFF; h_tab[2] = 24'h0000FF;
    run_sweep(32'd10, 24'h000100, BASE_A, 1'b1);
    n_tests++;
    if (nfill !== 3) begin
      n_fail++; $display("FAIL hit_fills: got %0d exp 3", nfill);
    end
    for (int i = 0; i < 3; i++) begin
      n_tests++;
      if (fill_nonce[i] !== NW'(i) || fill_base[i] !== BASE_A) begin
        n_fail++;
        $display("FAIL hit_block%0d: got %h_%h exp %h_%h", i, fill_base[i], fill_nonce[i], BASE_A, NW'(i));
      end
    end
    n_tests++;
    if (fill_cyc[0] !== 0 || fill_cyc[1] !== 3) begin
      n_fail++;
      $display("FAIL hit_fill_timing: got %0d,%0d exp 0,3", fill_cyc[0], fill_cyc[1]);
    end
    n_tests++;
    if (done_cyc < 0 || done_cyc !== last_hv_cyc + 1) begin
      n_fail++; $display("FAIL hit_done_latency: done at %0d exp %0d", done_cyc, last_hv_cyc + 1);
    end
    n_tests++;
    if (sif.found !== 1'b1 || sif.nonce_found !== 32'd2 || sif.hash_found !== 24'h0000FF) begin
      n_fail++;
      $display("FAIL hit_result: found=%b nonce=%h hash=%h exp 1 2 0000ff",
               sif.found, sif.nonce_found, sif.hash_found);
    end
    n_tests++;
    if (sif.attempts !== 33'd3 || sif.busy !== 1'b1) begin
      n_fail++; $display("FAIL hit_attempts: att=%0d busy=%b exp 3 1", sif.attempts, sif.busy);
    end
    @(negedge clk);
    n_tests++;
    if (sif.done !== 1'b0 || sif.busy !== 1'b0 || sif.found !== 1'b1) begin
      n_fail++;
      $display("FAIL hit_after_done: done=%b busy=%b found=%b exp 0 0 1", sif.done, sif.busy, sif.found);
    end
  endtask

  task automatic test_exhaust();
    for (int i = 0; i < 16; i++) h_tab[i] = 24'hFFFFFF;
    run_sweep(32'd4, 24'h000100, BASE_A, 1'b1);
    n_tests++;
    if (nfill !== 5 || fill_nonce[4] !== 32'd4) begin
      n_fail++; $display("FAIL exh_fills: got %0d last nonce %h exp 5 4", nfill, fill_nonce[4]);
    end
    n_tests++;
    if (sif.found !== 1'b0 || sif.attempts !== 33'd5 || sif.timeout_err !== 1'b0) begin
      n_fail++;
      $display("FAIL exh_result: found=%b att=%0d to=%b exp 0 5 0", sif.found, sif.attempts, sif.timeout_err);
    end
    n_tests++;
    if (done_cyc < 0 || done_cyc !== last_hv_cyc + 1) begin
      n_fail++; $display("FAIL exh_done_latency: done at %0d exp %0d", done_cyc, last_hv_cyc + 1);
    end
    @(negedge clk);
  endtask

  task automatic test_timeout();
    run_sweep(32'd3, 24'h000100, BASE_A, 1'b0);
    n_tests++;
    if (nfill !== 1 || done_cyc < 0 || done_cyc - fill_cyc[0] !== TO + 1) begin
      n_fail++;
      $display("FAIL to_done_timing: fills=%0d delay=%0d exp 1 %0d", nfill, done_cyc - fill_cyc[0], TO + 1);
    end
    n_tests++;
    if (sif.timeout_err !== 1'b1 || sif.attempts !== '0 || sif.found !== 1'b0) begin
      n_fail++;
      $display("FAIL to_result: to=%b att=%0d found=%b exp 1 0 0", sif.timeout_err, sif.attempts, sif.found);
    end
    @(negedge clk);
  endtask

  task automatic test_abort_stray();
    sif.base = BASE_A; sif.max_nonce = 32'd10; sif.target = 24'h000100; sif.start = 1'b1;
    @(negedge clk);
    n_tests++;
    if (sif.fill !== 1'b1 || sif.timeout_err !== 1'b0) begin
      n_fail++; $display("FAIL ab_fill: fill=%b to=%b exp 1 0", sif.fill, sif.timeout_err);
    end
    // Start while busy, with different config: must be ignored.
    sif.base = BASE_B; sif.max_nonce = 32'd0; sif.start = 1'b1;
    @(negedge clk);
    sif.start = 1'b0;
    n_tests++;
    if (sif.busy !== 1'b1 || sif.fill !== 1'b0 || sif.done !== 1'b0) begin
      n_fail++; $display("FAIL ab_start_busy: busy=%b fill=%b done=%b exp 1 0 0", sif.busy, sif.fill, sif.done);
    end
    // Abort together with a hash that would hit.
    sif.abort = 1'b1; sif.hash_valid = 1'b1; sif.H = 24'h000000;
    @(negedge clk);
    sif.abort = 1'b0; sif.hash_valid = 1'b0;
    n_tests++;
    if (sif.done !== 1'b1 || sif.aborted !== 1'b1 || sif.found !== 1'b0 || sif.attempts !== '0) begin
      n_fail++;
      $display("FAIL ab_result: done=%b ab=%b found=%b att=%0d exp 1 1 0 0",
               sif.done, sif.aborted, sif.found, sif.attempts);
    end
    @(negedge clk);
    n_tests++;
    if (sif.busy !== 1'b0 || sif.bloque_in[BW-1:NW] !== BASE_A) begin
      n_fail++; $display("FAIL ab_after: busy=%b base=%h exp 0 %h", sif.busy, sif.bloque_in[BW-1:NW], BASE_A);
    end
    // hash_valid while idle: ignored.
    sif.hash_valid = 1'b1; sif.H = 24'h000000;
    @(negedge clk);
    sif.hash_valid = 1'b0;
    @(negedge clk);
    n_tests++;
    if (sif.busy !== 1'b0 || sif.found !== 1'b0 || sif.attempts !== '0 || sif.aborted !== 1'b1) begin
      n_fail++;
      $display("FAIL idle_hv: busy=%b found=%b att=%0d ab=%b exp 0 0 0 1",
               sif.busy, sif.found, sif.attempts, sif.aborted);
    end
  endtask

  task automatic test_boundary();
    h_tab[0] = 24'h000010; h_tab[1] = 24'h00000F;
    run_sweep(32'd5, 24'h000010, BASE_B, 1'b1);
    n_tests++;
    if (nfill !== 2 || sif.found !== 1'b1 || sif.nonce_found !== 32'd1 || sif.hash_found !== 24'h00000F) begin
      n_fail++;
      $display("FAIL bnd_result: fills=%0d found=%b nonce=%h hash=%h exp 2 1 1 00000f",
               nfill, sif.found, sif.nonce_found, sif.hash_found);
    end
    n_tests++;
    if (sif.attempts !== 33'd2 || sif.aborted !== 1'b0 || fill_base[1] !== BASE_B) begin
      n_fail++;
      $display("FAIL bnd_misc: att=%0d ab=%b base=%h exp 2 0 %h", sif.attempts, sif.aborted, fill_base[1], BASE_B);
    end
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b0;
    sif.start = 1'b0; sif.abort = 1'b0; sif.hash_valid = 1'b0; sif.H = '0;
    sif.base = '0; sif.max_nonce = '0; sif.target = '0;
    for (int i = 0; i < 16; i++) h_tab[i] = 24'hFFFFFF;
    @(negedge clk);
    test_reset();
    test_hit();
    test_exhaust();
    test_timeout();
    test_abort_stray();
    test_boundary();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
